// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state encodings,
// opcodes, datapath mux/ALU select codes and the control-word payload.
package mc_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB  = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR  = 4'd5;
  localparam logic [STATE_W-1:0] S_REXE   = 4'd6;
  localparam logic [STATE_W-1:0] S_RWB    = 4'd7;
  localparam logic [STATE_W-1:0] S_AEXE   = 4'd8;
  localparam logic [STATE_W-1:0] S_AWB    = 4'd9;
  localparam logic [STATE_W-1:0] S_BEQ    = 4'd10;
  localparam logic [STATE_W-1:0] S_JMP    = 4'd11;
  localparam logic [STATE_W-1:0] S_ILL    = 4'd12;
  localparam logic [STATE_W-1:0] S_TOUT   = 4'd13;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // DECODE dispatch: unknown opcodes trap into ILL.
  function automatic logic [STATE_W-1:0] decode_target(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEMADR;
      OP_RTYPE:     return S_REXE;
      OP_BEQ:       return S_BEQ;
      OP_ADDI:      return S_AEXE;
      OP_J:         return S_JMP;
      default:      return S_ILL;
    endcase
  endfunction

endpackage

// File: rtl/mc_if.sv
// Unified instruction/data memory handshake between the control unit and memory.
interface mc_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_wait_timer.sv
// Consecutive memory wait-cycle counter; expired flags the watchdog limit.
module mc_wait_timer #(
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WAIT_W'(1);
    end
  end

  // A limit of zero disables the watchdog entirely.
  assign expired = (WAIT_MAX != 0) && (count == WAIT_W'(WAIT_MAX));

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM sharing one ALU and one memory, with
// wait watchdog, illegal-opcode trap and retired-instruction counter.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  mc_if.master                mem,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [CNT_W-1:0]    retired,
  output logic                illegal,
  output logic                err_timeout,
  output logic [STATE_W-1:0]  state
);

  logic [STATE_W-1:0] state_nxt;
  ctrl_t              ctrl;
  logic               retire;
  logic               wait_expired;
  logic               wait_clr;
  logic               wait_inc;

  // Branch gating on zero happens in the datapath via pc_write_cond.
  logic zero_unused;
  assign zero_unused = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_src    = PC_ALU;
          state_nxt      = S_DECODE;
        end else if (wait_expired) begin
          state_nxt = S_TOUT;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        state_nxt      = decode_target(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_nxt      = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem.mem_ready) begin
          state_nxt = S_MEMWB;
        end else if (wait_expired) begin
          state_nxt = S_TOUT;
        end
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire          = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem.mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (wait_expired) begin
          state_nxt = S_TOUT;
        end
      end
      S_REXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        state_nxt      = S_RWB;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        retire         = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_AEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_nxt      = S_AWB;
      end
      S_AWB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_ALUOUT;
        retire             = 1'b1;
        state_nxt          = S_FETCH;
      end
      S_JMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_JUMP;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_ILL, S_TOUT: state_nxt = state;
      default:       state_nxt = S_FETCH;
    endcase
    // A reset cycle aborts the instruction: no strobe may reach the datapath.
    if (rst) begin
      ctrl   = '0;
      retire = 1'b0;
    end
  end

  assign wait_inc = ctrl.mem_req & ~mem.mem_ready;
  assign wait_clr = (state_nxt != state);

  mc_wait_timer #(
    .WAIT_W  (WAIT_W),
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .expired(wait_expired)
  );

  // Retire counter and sticky trap flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired     <= '0;
      illegal     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
      if (state_nxt == S_ILL) begin
        illegal <= 1'b1;
      end
      if (state_nxt == S_TOUT) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign mem.mem_req    = ctrl.mem_req;
  assign mem.mem_we     = ctrl.mem_we;
  assign mem.iord       = ctrl.iord;
  assign ir_write       = ctrl.ir_write;
  assign pc_write       = ctrl.pc_write;
  assign pc_write_cond  = ctrl.pc_write_cond;
  assign pc_src         = ctrl.pc_src;
  assign alu_src_a      = ctrl.alu_src_a;
  assign alu_src_b      = ctrl.alu_src_b;
  assign alu_op         = ctrl.alu_op;
  assign reg_dst        = ctrl.reg_dst;
  assign mem_to_reg     = ctrl.mem_to_reg;
  assign reg_write      = ctrl.reg_write;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: instruction-level reference model with randomized
// memory wait patterns, plus directed reset, watchdog, trap and wrap cases.
module tb_mc_control;
  import mc_pkg::*;

  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 15;

  logic                clk;
  logic                rst;
  logic [5:0]          opcode;
  logic                zero;
  logic                ir_write, pc_write, pc_write_cond;
  logic [1:0]          pc_src, alu_src_b, alu_op;
  logic                alu_src_a, reg_dst, mem_to_reg, reg_write;
  logic [CNT_W-1:0]    retired;
  logic                illegal, err_timeout;
  logic [3:0]          state;

  mc_if bus ();

  mc_control #(
    .CNT_W   (CNT_W),
    .WAIT_MAX(WAIT_MAX),
    .WAIT_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .zero         (zero),
    .mem          (bus),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .retired      (retired),
    .illegal      (illegal),
    .err_timeout  (err_timeout),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [CNT_W-1:0] exp_ret;
  bit               exp_ill;
  bit               exp_to;

  logic [15:0] obs_ctl;
  assign obs_ctl = {bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_write, pc_write_cond,
                    pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Control word each state must present, straight from the state action table.
  function automatic logic [15:0] exp_ctl(input logic [3:0] p, input logic rdy);
    logic req, we, iord, irw, pcw, pcwc, sa, rd, m2r, rw;
    logic [1:0] pcs, sb, aop;
    {req, we, iord, irw, pcw, pcwc, sa, rd, m2r, rw} = '0;
    {pcs, sb, aop} = '0;
    case (p)
      S_FETCH:  begin req = 1; if (rdy) begin irw = 1; pcw = 1; sb = 2'b01; end end
      S_DECODE: sb = 2'b11;
      S_MEMADR: begin sa = 1; sb = 2'b10; end
      S_MEMRD:  begin req = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin req = 1; we = 1; iord = 1; end
      S_REXE:   begin sa = 1; aop = 2'b10; end
      S_RWB:    begin rw = 1; rd = 1; end
      S_AEXE:   begin sa = 1; sb = 2'b10; end
      S_AWB:    rw = 1;
      S_BEQ:    begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      S_JMP:    begin pcw = 1; pcs = 2'b10; end
      default:  ;
    endcase
    return {req, we, iord, irw, pcw, pcwc, pcs, sa, sb, aop, rd, m2r, rw};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive ready, check every output mid-cycle, advance.
  task automatic cycle(input logic [3:0] p, input logic rdy);
    rst           = 1'b0;
    bus.mem_ready = rdy;
    zero          = rnd_bit();
    @(negedge clk);
    check($sformatf("state(p%0d)", p), 32'(state), 32'(p));
    check($sformatf("ctl(p%0d,rdy%0d)", p, rdy), 32'(obs_ctl), 32'(exp_ctl(p, rdy)));
    check("retired", 32'(retired), 32'(exp_ret));
    check("illegal", 32'(illegal), 32'(exp_ill));
    check("err_timeout", 32'(err_timeout), 32'(exp_to));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input logic rdy);
    rst           = 1'b1;
    bus.mem_ready = rdy;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_strobes", 32'({reg_write, pc_write, pc_write_cond, ir_write}), 32'd0);
      @(posedge clk);
      #1;
    end
    rst     = 1'b0;
    exp_ret = '0;
    exp_ill = 1'b0;
    exp_to  = 1'b0;
  endtask

  // Memory phase: w wait cycles then ready; more than WAIT_MAX waits times out.
  task automatic mem_phase(input logic [3:0] p, input int w, output bit to);
    to = 1'b0;
    for (int i = 0; i < w && i <= WAIT_MAX; i++) cycle(p, 1'b0);
    if (w > WAIT_MAX) to = 1'b1;
    else cycle(p, 1'b1);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit to;
    opcode = op;
    mem_phase(S_FETCH, fw, to);
    if (!to) begin
      cycle(S_DECODE, rnd_bit());
      case (op)
        OP_LW: begin
          cycle(S_MEMADR, rnd_bit());
          mem_phase(S_MEMRD, mw, to);
          if (!to) cycle(S_MEMWB, rnd_bit());
        end
        OP_SW: begin
          cycle(S_MEMADR, rnd_bit());
          mem_phase(S_MEMWR, mw, to);
        end
        OP_RTYPE: begin cycle(S_REXE, rnd_bit()); cycle(S_RWB, rnd_bit()); end
        OP_ADDI:  begin cycle(S_AEXE, rnd_bit()); cycle(S_AWB, rnd_bit()); end
        OP_BEQ:   cycle(S_BEQ, rnd_bit());
        OP_J:     cycle(S_JMP, rnd_bit());
        default: begin
          exp_ill = 1'b1;
          repeat (2) cycle(S_ILL, rnd_bit());
          return;
        end
      endcase
    end
    if (to) begin
      exp_to = 1'b1;
      repeat (2) cycle(S_TOUT, rnd_bit());
      return;
    end
    exp_ret++;
  endtask

  logic [5:0] ops [7] = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, 6'b010001};

  initial begin
    rst = 1'b1; opcode = '0; zero = 1'b0; bus.mem_ready = 1'b0;
    exp_ret = '0; exp_ill = 1'b0; exp_to = 1'b0;
    do_reset(2, 1'b0);

    run_instr(OP_LW, 0, 0);
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_ADDI, 3, 0);

    // Reset while waiting in MEMRD, then during RWB and a ready FETCH.
    opcode = OP_LW;
    cycle(S_FETCH, 1'b1); cycle(S_DECODE, 1'b0); cycle(S_MEMADR, 1'b0);
    cycle(S_MEMRD, 1'b0); cycle(S_MEMRD, 1'b0);
    do_reset(2, 1'b0);
    opcode = OP_RTYPE;
    cycle(S_FETCH, 1'b1); cycle(S_DECODE, 1'b0); cycle(S_REXE, 1'b0);
    do_reset(1, 1'b1);
    opcode = OP_J;
    do_reset(1, 1'b1);

    // Ready arriving exactly at the limit wins over the watchdog.
    run_instr(OP_SW, 0, WAIT_MAX);
    run_instr(OP_LW, WAIT_MAX, 2);
    run_instr(OP_SW, 0, WAIT_MAX + 1);
    do_reset(1, 1'b0);
    run_instr(OP_J, WAIT_MAX + 1, 0);
    do_reset(1, 1'b0);
    run_instr(6'b111111, 0, 0);
    do_reset(1, 1'b0);

    repeat (17) run_instr(OP_J, 0, 0);
    @(negedge clk);
    check("retired_wrap", 32'(retired), 32'd1);
    @(posedge clk);
    #1;

    do_reset(1, 1'b0);
    repeat (60) begin
      int fw, mw;
      logic [5:0] op;
      op = ops[$urandom_range(0, 6)];
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WAIT_MAX + 1)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WAIT_MAX + 1)) : int'($urandom_range(0, 2));
      run_instr(op, fw, mw);
      if (exp_to || exp_ill) do_reset(1, rnd_bit());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL sim_time_limit: got no completion expected $finish before 1ms");
    $fatal(1);
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle decode with a state machine that time-shares one ALU and one unified instruction/data memory.
- Memory access uses a req/ready handshake, so the core tolerates variable-latency memory.
- Adds a wait-cycle watchdog, illegal-opcode trap and retired-instruction counter; the counter feeds the seven-segment debug display.

Parameters:
- CNT_W, 32: width of retired-instruction counter.
- WAIT_MAX, 15: max consecutive wait cycles in a memory state before timeout; 0 disables watchdog.
- WAIT_W, 4: width of wait counter; must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
- clk  in  1  core clock (post clock divider).
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write access (valid with mem_req).
- iord  out  1  0 = address from PC, 1 = address from ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump address.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext, 11 sign-ext<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- retired  out  CNT_W  instructions completed.
- illegal  out  1  sticky illegal-opcode flag.
- err_timeout  out  1  sticky watchdog flag.
- state  out  4  current state encoding (debug).

Behaviour:
- Reset applies on the clk edge with rst=1.
  - State goes to FETCH; retired=0, illegal=0, err_timeout=0, wait counter=0.
  - A reset during any state, including a memory wait, aborts the instruction. No reg_write or pc_write is asserted in that cycle.
- Control outputs are combinational from state, plus mem_ready in memory states. All are 0 unless listed below.
- States and actions:
  - FETCH: mem_req=1, iord=0.
    - If mem_ready: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; go to DECODE.
    - Otherwise stay.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 100011/101011 go to MEMADR.
    - 000000 goes to REXE.
    - 000100 goes to BEQ.
    - 001000 goes to AEXE.
    - 000010 goes to JMP.
    - Any other opcode goes to ILL.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD: mem_req=1, iord=1. Goes to MEMWB on mem_ready.
  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; retire; go to FETCH.
  - MEMWR: mem_req=1, mem_we=1, iord=1. On mem_ready: retire, go to FETCH.
  - REXE: alu_src_a=1, alu_src_b=00, alu_op=10; go to RWB.
  - RWB: reg_write=1, reg_dst=1, mem_to_reg=0; retire; go to FETCH.
  - AEXE: alu_src_a=1, alu_src_b=10, alu_op=00; go to AWB.
  - AWB: reg_write=1, reg_dst=0, mem_to_reg=0; retire; go to FETCH.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; retire; go to FETCH.
  - JMP: pc_write=1, pc_src=10; retire; go to FETCH.
  - ILL: illegal=1; all strobes 0; terminal until rst.
  - TOUT: err_timeout=1; all strobes 0; terminal until rst.
- Latency with zero-wait memory (mem_ready high when first requested):
  - lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each wait cycle adds 1.
- Watchdog (memory states FETCH, MEMRD, MEMWR):
  - The counter increments each cycle with mem_req=1 and mem_ready=0, and clears on state exit.
  - If the counter equals WAIT_MAX and mem_ready=0, the next state is TOUT.
  - If mem_ready arrives on that same cycle, ready wins.
  - WAIT_MAX=0 means the watchdog never fires.
- Retire: retired increments by 1 on the final cycle of each instruction and wraps modulo 2^CNT_W.
- A beq counts as retired whether or not it is taken.

Decomposition:
- Package mc_pkg holds:
  - state localparams, 4-bit encoding with FETCH=0;
  - opcode constants;
  - alu_op, alu_src_b and pc_src codes.
- Sub-module mc_wait_timer (WAIT_W, WAIT_MAX): inputs clk, rst, clr, inc; output expired.

Test Plan:
- rst=1 for 2 cycles mid-MEMRD wait -> state=0, retired=0, flags 0, no reg_write in the reset cycles.
- lw (op 100011) with mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write and mem_to_reg high in cycle 5; retired=1.
- R-type, then beq with zero=1, then j; mem_ready=1 -> 4/3/3 cycles; pc_write_cond with pc_src=01 in beq; pc_src=10 in j; retired=3.
- FETCH with mem_ready delayed 3 cycles -> mem_req held 4 cycles; ir_write only in the 4th; no timeout.
- WAIT_MAX=15, mem_ready never asserted in MEMWR -> TOUT entered after 16 cycles in MEMWR; err_timeout sticky; mem_req=0.
- Opcode 111111 -> ILL after DECODE; illegal=1; retired unchanged; rst clears it.
- CNT_W=4, 17 back-to-back j instructions -> retired=1 (wrap).
